// File: rtl/target_scheduler.sv
// target_scheduler
// Game-side controller that turns the generator's random target index into
// a live set of on-screen targets. Once per game tick it ages the live
// targets, expires old ones as misses and spawns a new target. Between ticks
// it accepts player hits and scores them. It also returns a never-zero
// modulus (score + 11) to the random generator.
//
// Ports:
//   clock        in   system clock, posedge
//   reset        in   asynchronous active-high reset
//   start        in   pulse: start/restart a game from IDLE or OVER
//   ranNumTen    in   random target index, sampled on tick only
//   hit_valid    in   pulse: player strike
//   hit_idx      in   index of the struck target
//   active_mask  out  bit i set = target i live
//   score        out  accumulated points (saturating)
//   rng_modulus  out  score + 11
//   misses       out  expired-target count (saturating at MAX_MISSES)
//   spawn_pulse  out  one-cycle pulse when a target spawns
//   wrong_hit    out  one-cycle pulse for a hit on an inactive/invalid index
//   game_over    out  high while in OVER
module target_scheduler #(
  parameter int NUM_TARGETS = 10,       // 1..16, indices fit the 4-bit ports
  parameter int TICK_DIV    = 25000000,
  parameter int LIFETIME    = 6,        // 1..15
  parameter int MAX_MISSES  = 5         // 1..255
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [3:0]             ranNumTen,
  input  logic                   hit_valid,
  input  logic [3:0]             hit_idx,
  output logic [NUM_TARGETS-1:0] active_mask,
  output logic [31:0]            score,
  output logic [31:0]            rng_modulus,
  output logic [7:0]             misses,
  output logic                   spawn_pulse,
  output logic                   wrong_hit,
  output logic                   game_over
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_OVER = 2'd2
  } state_t;

  localparam int            CW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TICK_LAST  = CW'(TICK_DIV - 1);
  localparam logic [31:0]   SCORE_MAX  = 32'hFFFF_FFF0;
  localparam logic [31:0]   MOD_OFFSET = 32'd11;

  state_t                 state_r, state_s;
  logic [CW-1:0]          tick_cnt_r, tick_cnt_s;
  logic [3:0]             ages_r [NUM_TARGETS];
  logic [3:0]             ages_s [NUM_TARGETS];
  logic [NUM_TARGETS-1:0] mask_s;
  logic [31:0]            score_s;
  logic [7:0]             misses_s;
  logic                   spawn_s;
  logic                   wrong_s;
  logic                   tick_s;
  logic [3:0]             pts_s;
  logic [32:0]            score_sum_s;
  logic [3:0]             age_inc_s;
  logic [4:0]             exp_cnt_s;
  logic [8:0]             miss_sum_s;
  logic [4:0]             probe_s;
  logic [3:0]             spawn_slot_s;
  logic                   found_s;

  // Game tick: last count of the divider, only while a game is running.
  assign tick_s = (state_r == S_RUN) && (tick_cnt_r == TICK_LAST);

  // Next-state logic: hit, then age/expire, then spawn, all in one cycle.
  always_comb begin
    state_s      = state_r;
    tick_cnt_s   = tick_cnt_r;
    mask_s       = active_mask;
    ages_s       = ages_r;
    score_s      = score;
    misses_s     = misses;
    spawn_s      = 1'b0;
    wrong_s      = 1'b0;
    pts_s        = 4'd0;
    score_sum_s  = 33'd0;
    age_inc_s    = 4'd0;
    exp_cnt_s    = 5'd0;
    miss_sum_s   = 9'd0;
    probe_s      = 5'd0;
    spawn_slot_s = 4'd0;
    found_s      = 1'b0;

    case (state_r)
      S_IDLE, S_OVER: begin
        // Hits are ignored here; score/misses hold until the next start.
        if (start) begin
          state_s    = S_RUN;
          tick_cnt_s = '0;
          mask_s     = '0;
          score_s    = 32'd0;
          misses_s   = 8'd0;
          for (int i = 0; i < NUM_TARGETS; i++) begin
            ages_s[i] = 4'd0;
          end
        end else begin
          state_s = state_r;
        end
      end

      S_RUN: begin
        if (tick_s) begin
          tick_cnt_s = '0;
        end else begin
          tick_cnt_s = tick_cnt_r + CW'(1);
        end

        // Hit: scored against the pre-tick age, so a target about to
        // expire on this tick still earns its last point.
        if (hit_valid) begin
          if (({1'b0, hit_idx} < 5'(NUM_TARGETS)) && active_mask[hit_idx]) begin
            pts_s       = 4'(LIFETIME) - ages_r[hit_idx];
            score_sum_s = {1'b0, score} + {29'd0, pts_s};
            if (score_sum_s > {1'b0, SCORE_MAX}) begin
              score_s = SCORE_MAX;
            end else begin
              score_s = score_sum_s[31:0];
            end
            mask_s[hit_idx] = 1'b0;
            ages_s[hit_idx] = 4'd0;
          end else begin
            wrong_s = 1'b1;
          end
        end else begin
          wrong_s = 1'b0;
        end

        if (tick_s) begin
          // Age the survivors of the hit step; count expiries.
          for (int i = 0; i < NUM_TARGETS; i++) begin
            if (mask_s[i]) begin
              age_inc_s = ages_s[i] + 4'd1;
              if (age_inc_s == 4'(LIFETIME)) begin
                mask_s[i] = 1'b0;
                ages_s[i] = 4'd0;
                exp_cnt_s = exp_cnt_s + 5'd1;
              end else begin
                ages_s[i] = age_inc_s;
              end
            end else begin
              ages_s[i] = ages_s[i];
            end
          end

          miss_sum_s = {1'b0, misses} + {4'd0, exp_cnt_s};
          if (miss_sum_s >= 9'(MAX_MISSES)) begin
            // Game ends on this edge: board clears, nothing spawns.
            misses_s = 8'(MAX_MISSES);
            state_s  = S_OVER;
            mask_s   = '0;
            for (int i = 0; i < NUM_TARGETS; i++) begin
              ages_s[i] = 4'd0;
            end
          end else begin
            misses_s = miss_sum_s[7:0];
            if ({1'b0, ranNumTen} < 5'(NUM_TARGETS)) begin
              // Linear probe upward (mod NUM_TARGETS) from the candidate.
              for (int j = 0; j < NUM_TARGETS; j++) begin
                probe_s = {1'b0, ranNumTen} + 5'(j);
                if (probe_s >= 5'(NUM_TARGETS)) begin
                  probe_s = probe_s - 5'(NUM_TARGETS);
                end else begin
                  probe_s = probe_s;
                end
                if (!found_s && !mask_s[probe_s[3:0]]) begin
                  found_s      = 1'b1;
                  spawn_slot_s = probe_s[3:0];
                end else begin
                  found_s = found_s;
                end
              end
              if (found_s) begin
                mask_s[spawn_slot_s] = 1'b1;
                ages_s[spawn_slot_s] = 4'd0;
                spawn_s              = 1'b1;
              end else begin
                spawn_s = 1'b0;
              end
            end else begin
              spawn_s = 1'b0;
            end
          end
        end else begin
          misses_s = misses;
        end
      end

      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // State and output registers; rng_modulus tracks the new score value.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r     <= S_IDLE;
      tick_cnt_r  <= '0;
      active_mask <= '0;
      score       <= 32'd0;
      rng_modulus <= MOD_OFFSET;
      misses      <= 8'd0;
      spawn_pulse <= 1'b0;
      wrong_hit   <= 1'b0;
      game_over   <= 1'b0;
      for (int i = 0; i < NUM_TARGETS; i++) begin
        ages_r[i] <= 4'd0;
      end
    end else begin
      state_r     <= state_s;
      tick_cnt_r  <= tick_cnt_s;
      active_mask <= mask_s;
      score       <= score_s;
      rng_modulus <= score_s + MOD_OFFSET;
      misses      <= misses_s;
      spawn_pulse <= spawn_s;
      wrong_hit   <= wrong_s;
      game_over   <= (state_s == S_OVER);
      for (int i = 0; i < NUM_TARGETS; i++) begin
        ages_r[i] <= ages_s[i];
      end
    end
  end

endmodule
